fetch_redirect_unit: RTL

Front-end PC owner for the 64-bit core. Holds the fetch PC and issues in-order instruction fetch requests over a valid/ready interface. Hands fetched instructions to decode with their PC. Consumes the branch-taken decision from the branch comparator and the branch target; on a taken branch it redirects the PC, flushes buffered instructions and discards stale in-flight responses.

---
 rtl/fetch_redirect_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_unit.sv
// Front-end PC owner: issues in-order fetches, queues returned instructions for decode,
// and redirects on taken branches while dropping stale responses. Optional counters: FETCH_STATS_EN.
module fetch_redirect_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_valid,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   input  logic        stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [63:0] instr_pc,
   output logic        flush
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] redirect_count,
   output logic [31:0] discard_count
`endif
);

   localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned CW1 = CW + 1;
   localparam int unsigned NE  = 2 ** PW;
   localparam logic [CW:0] DEPTH_L = CW1'(DEPTH);

   typedef enum logic {FETCH, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [63:0]     pc_q, pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d, q_cnt_q, q_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]   out_wp_q, out_wp_d, out_rp_q, out_rp_d;
   logic [PW-1:0]   q_wp_q, q_wp_d, q_rp_q, q_rp_d;
   logic [63:0]     addr_mem [NE];
   logic [31:0]     ins_mem  [NE];
   logic [63:0]     ipc_mem  [NE];

   logic            redirect, occ_ok, req_fire, rsp_fetch, rsp_drain;
   logic            push_q, pop_q, discard;
   logic [CW-1:0]   stale;
   logic            unused_tgt_lsb;

   assign unused_tgt_lsb = ^branch_target[1:0];

   assign redirect       = branch_valid & branch_taken & ~reset;
   assign flush          = redirect;
   assign occ_ok         = ({1'b0, out_cnt_q} + {1'b0, q_cnt_q}) < DEPTH_L;
   assign imem_req_valid = ~reset & (state_q == FETCH) & ~stall & ~redirect & occ_ok;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Responses only count while something is owed; in DRAIN they are owed to drop_cnt.
   assign rsp_fetch = (state_q == FETCH) & imem_rsp_valid & (out_cnt_q != '0);
   assign rsp_drain = (state_q == DRAIN) & imem_rsp_valid & (drop_cnt_q != '0);
   assign push_q    = rsp_fetch & ~redirect;
   assign discard   = (rsp_fetch & redirect) | rsp_drain;
   assign stale     = out_cnt_q + drop_cnt_q - CW'(discard);

   assign instr_valid = (q_cnt_q != '0);
   assign pop_q       = instr_valid & instr_ready & ~redirect;
   assign instr_out   = instr_valid ? ins_mem[q_rp_q] : '0;
   assign instr_pc    = instr_valid ? ipc_mem[q_rp_q] : '0;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_cnt_d = drop_cnt_q;
      out_wp_d   = req_fire  ? out_wp_q + PW'(1) : out_wp_q;
      out_rp_d   = rsp_fetch ? out_rp_q + PW'(1) : out_rp_q;
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_fetch);
      q_wp_d     = push_q ? q_wp_q + PW'(1) : q_wp_q;
      q_rp_d     = pop_q  ? q_rp_q + PW'(1) : q_rp_q;
      q_cnt_d    = q_cnt_q + CW'(push_q) - CW'(pop_q);
      if (redirect) begin
         pc_d       = {branch_target[63:2], 2'b00};
         out_wp_d   = '0;
         out_rp_d   = '0;
         out_cnt_d  = '0;
         q_wp_d     = '0;
         q_rp_d     = '0;
         q_cnt_d    = '0;
         drop_cnt_d = stale;
         state_d    = (stale != '0) ? DRAIN : FETCH;
      end else if (state_q == FETCH) begin
         if (req_fire) pc_d = pc_q + 64'd4;
      end else if (rsp_drain) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
         if (drop_cnt_q == CW'(1)) state_d = FETCH;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         out_wp_q   <= '0;
         out_rp_q   <= '0;
         q_cnt_q    <= '0;
         q_wp_q     <= '0;
         q_rp_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         out_wp_q   <= out_wp_d;
         out_rp_q   <= out_rp_d;
         q_cnt_q    <= q_cnt_d;
         q_wp_q     <= q_wp_d;
         q_rp_q     <= q_rp_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: occupancy counters define which entries are live.
   always_ff @(posedge clk) begin
      if (req_fire) addr_mem[out_wp_q] <= pc_q;
      if (push_q) begin
         ins_mem[q_wp_q] <= imem_rsp_data;
         ipc_mem[q_wp_q] <= addr_mem[out_rp_q];
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect_count <= '0;
         discard_count  <= '0;
      end else begin
         if (redirect && (redirect_count != '1)) redirect_count <= redirect_count + 32'd1;
         if (discard && (discard_count != '1))   discard_count  <= discard_count + 32'd1;
      end
   end
`endif

endmodule
